conv_feed: RTL and testbench

CONV_FEED -- requirements
Module: conv_feed

---
 rtl/conv_feed_if.sv | 26 ++
 rtl/conv_feed.sv | 148 ++++++++++++++
 tb/tb_conv_feed.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_feed_if.sv
// Bundle between the sample producer, the burst feeder and the convolution stage.
// Carries the input handshake, the burst output pair with its framing flags, and status.
// The producer side (master) drives in_valid/in_data; the feeder side (slave) drives the rest.
interface conv_feed_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data0;
    logic signed [7:0] in_data1;
    logic signed [7:0] out_data0;
    logic signed [7:0] out_data1;
    logic              out_valid;
    logic              out_first;
    logic              out_last;
    logic              busy;
    logic [7:0]        frame_cnt;

    modport master (
        output in_valid, in_data0, in_data1,
        input  in_ready, out_data0, out_data1, out_valid, out_first, out_last, busy, frame_cnt
    );

    modport slave (
        input  in_valid, in_data0, in_data1,
        output in_ready, out_data0, out_data1, out_valid, out_first, out_last, busy, frame_cnt
    );
endinterface

// File: rtl/conv_feed.sv
// Buffers signed sample pairs and releases them as FRAME_LEN-sample bursts separated by GAP_LEN idle cycles.
// Latency: first burst sample appears one cycle after the edge that sees FRAME_LEN stored pairs.
// Backpressure: in_ready drops only while the pair FIFO is full; pushes are accepted in every state.
module conv_feed #(
    parameter int FRAME_LEN  = 8,
    parameter int GAP_LEN    = 40,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    conv_feed_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] OCC_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] OCC_FRAME = CW'(FRAME_LEN);
    localparam logic [IW-1:0] IDX_END   = IW'(FRAME_LEN);
    localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_END   = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
    } pair_t;

    pair_t          mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  occ;
    logic           push;
    logic           pop;
    logic           start;
    logic           more;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [GW-1:0]  gap_cnt;
    pair_t          out_pair;
    logic           out_valid;
    logic           out_first;
    logic           out_last;
    logic [7:0]     frame_cnt;

    // idx counts pairs already popped in the current burst; when it reaches
    // FRAME_LEN the last sample is on the outputs and nothing more is popped.
    assign bus.in_ready = (occ < OCC_FULL);
    assign push         = bus.in_valid & bus.in_ready;
    assign start        = (state == IDLE) && (occ >= OCC_FRAME);
    assign more         = (state == BURST) && (idx != IDX_END);
    assign pop          = start | more;

    // Pair storage; no reset needed because the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= {bus.in_data0, bus.in_data1};
        end
    end

    // Pointer and occupancy bookkeeping; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Burst sequencer: IDLE waits for a full frame, BURST streams it with registered
    // outputs, GAP holds off the next frame while the convolution stage works.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            out_pair  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            out_pair  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BURST;
                        out_pair  <= mem[rd_ptr];
                        out_valid <= 1'b1;
                        out_first <= 1'b1;
                        out_last  <= (FRAME_LEN == 1);
                        idx       <= IW'(1);
                    end
                end
                BURST: begin
                    if (more) begin
                        out_pair  <= mem[rd_ptr];
                        out_valid <= 1'b1;
                        out_last  <= (idx == IDX_LAST);
                        idx       <= idx + 1'b1;
                    end else begin
                        // Last sample is being presented this cycle.
                        state     <= (GAP_LEN == 0) ? IDLE : GAP;
                        idx       <= '0;
                        gap_cnt   <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data0 = out_pair.d0;
    assign bus.out_data1 = out_pair.d1;
    assign bus.out_valid = out_valid;
    assign bus.out_first = out_first;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state != IDLE);
    assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_conv_feed.sv
// Bench for conv_feed: randomized pushes, queue scoreboard and an independent output monitor.
// Expected data order, burst framing, gap spacing and frame count come from the block's rules.
// Inputs change 1 time unit after the rising edge; the monitor samples at the same point.
module tb_conv_feed;
    localparam int FRAME_LEN  = 8;
    localparam int GAP_LEN    = 40;
    localparam int FIFO_DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_feed_if bus();

    conv_feed #(
        .FRAME_LEN (FRAME_LEN),
        .GAP_LEN   (GAP_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    int          gaps[$];
    bit          rst_edge = 0;
    bit          saw_full = 0;
    int          last_busy_run = 0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acceptance side: the scoreboard grows exactly when a transfer is accepted.
    initial begin
        bit prev_low = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_low) check("in_ready_during_reset", bus.in_ready, 1);
                exp_q.delete();
                rst_edge = 1;
                prev_low = 1;
            end else begin
                prev_low = 0;
                check("in_ready", bus.in_ready, (exp_q.size() < FIFO_DEPTH) ? 1 : 0);
                if (!bus.in_ready) saw_full = 1;
                if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_data0, bus.in_data1});
            end
        end
    end

    // Output monitor: pops the scoreboard whenever a burst sample is presented.
    initial begin
        int          pos = 0;
        int          fc = 0;
        int          idle = 0;
        bit          have_last = 0;
        int          busy_run = 0;
        logic [15:0] e;
        forever begin
            tick();
            if (rst_edge) begin
                rst_edge = 0;
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_frame_cnt", bus.frame_cnt, 0);
                pos = 0; fc = 0; idle = 0; have_last = 0; busy_run = 0;
            end
            check("frame_cnt", bus.frame_cnt, fc);
            if (bus.out_valid) begin
                check("queue_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_pair", {bus.out_data0, bus.out_data1}, e);
                end
                check("out_first", bus.out_first, (pos == 0) ? 1 : 0);
                check("out_last", bus.out_last, (pos == FRAME_LEN - 1) ? 1 : 0);
                check("busy_in_burst", bus.busy, 1);
                if (bus.out_first && have_last) begin
                    check("gap_min", (idle >= GAP_LEN + 1) ? 1 : 0, 1);
                    gaps.push_back(idle);
                end
                pos = (pos + 1) % FRAME_LEN;
                if (bus.out_last) begin
                    fc = (fc + 1) % 256;
                    idle = 0;
                    have_last = 1;
                end
            end else begin
                check("idle_outputs_zero", {bus.out_data0, bus.out_data1, bus.out_first, bus.out_last}, 0);
                check("burst_contiguous", pos, 0);
                pos = 0;
                if (have_last) idle++;
            end
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, FRAME_LEN + GAP_LEN);
                last_busy_run = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data0 = a;
        bus.in_data1 = b;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 1000);
        check("push_accepted", acc ? 1 : 0, 1);
    endtask

    task automatic stop_push();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_in_time", (n < 3000) ? 1 : 0, 1);
        tick();
    endtask

    task automatic do_reset();
        stop_push();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic push_random(input int count, input int max_gap);
        for (int i = 0; i < count; i++) begin
            push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (max_gap > 0) begin
                int g = $urandom_range(0, max_gap);
                if (g > 0) begin
                    stop_push();
                    repeat (g) tick();
                end
            end
        end
        stop_push();
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data0 = '0;
        bus.in_data1 = '0;
        reset        = 1'b0;
        tick();
        tick();
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_outputs", {bus.out_valid, bus.out_first, bus.out_last, bus.busy}, 0);
        check("reset_data", {bus.out_data0, bus.out_data1}, 0);
        check("reset_frame_cnt", bus.frame_cnt, 0);
        reset = 1'b1;

        // Single frame (1,-1)..(8,-8) back to back.
        for (int i = 1; i <= 8; i++) push_pair(8'(i), 8'(-i));
        stop_push();
        drain();
        check("single_frame_cnt", bus.frame_cnt, 1);
        check("single_busy_len", last_busy_run, FRAME_LEN + GAP_LEN);

        // Seven pairs never form a partial burst; the eighth starts one.
        do_reset();
        for (int i = 1; i <= 7; i++) push_pair(8'(i * 3), 8'(-i * 3));
        stop_push();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.out_valid) check("no_partial_burst", bus.out_valid, 0);
        end
        check("partial_wait_quiet", bus.out_valid, 0);
        push_pair(8'd24, 8'(-24));
        stop_push();
        check("latency_edge_seen", bus.out_valid, 0);
        tick();
        check("latency_first_valid", bus.out_valid, 1);
        check("latency_first_flag", bus.out_first, 1);
        drain();
        check("partial_frame_cnt", bus.frame_cnt, 1);

        // 24 pairs continuously: fills the FIFO, three back-to-back-gated bursts.
        do_reset();
        gaps.delete();
        saw_full = 0;
        push_random(24, 0);
        drain();
        check("cont_frame_cnt", bus.frame_cnt, 3);
        check("cont_saw_full", saw_full ? 1 : 0, 1);
        check("cont_gap_count", gaps.size(), 2);
        foreach (gaps[i]) check("cont_gap_exact", gaps[i], GAP_LEN + 1);

        // Keep pushing against a full FIFO while bursts pop.
        do_reset();
        push_random(48, 0);
        drain();
        check("full_frame_cnt", bus.frame_cnt, 6);

        // Extreme signed values.
        do_reset();
        push_pair(8'd127, 8'h80);
        push_pair(8'h80, 8'd127);
        push_random(6, 0);
        drain();
        check("extreme_frame_cnt", bus.frame_cnt, 1);

        // Reset in the middle of a burst, with a push offered during reset.
        do_reset();
        for (int i = 1; i <= 10; i++) push_pair(8'(i), 8'(-i));
        stop_push();
        n = 0;
        while (!(bus.out_valid && bus.out_data0 == 8'sd5) && n < 200) begin
            tick();
            n++;
        end
        check("abort_found_sample4", (n < 200) ? 1 : 0, 1);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data0 = 8'd99;
        bus.in_data1 = 8'd99;
        tick();
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_frame_cnt", bus.frame_cnt, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 1);
        tick();
        reset = 1'b1;
        stop_push();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) check("abort_no_stale", bus.out_valid, 0);
        end
        for (int i = 1; i <= 8; i++) push_pair(8'(100 + i), 8'(-100 - i));
        stop_push();
        drain();
        check("abort_clean_frame", bus.frame_cnt, 1);

        // Random traffic with idle gaps.
        do_reset();
        push_random(64, 3);
        drain();
        check("random_frame_cnt", bus.frame_cnt, 8);

        // 256 bursts: frame counter wraps to zero.
        do_reset();
        push_random(256 * FRAME_LEN, 0);
        drain();
        check("wrap_frame_cnt", bus.frame_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
